// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, constants and timing helper for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_tx_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_RETRIES    = 2;

  // 64-bit product: 15000 us at 48 MHz overflows 32 bits
  function automatic int us_to_cycles(input longint us, input longint freq);
    return int'((us * freq) / longint'(1000000));
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and status between sequencer and PS/2 transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic       tx_nack;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err, tx_nack
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err, tx_nack
  );
endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer plus 4-sample history for one PS/2 line
module ps2_line_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall,
  output logic rise
);
  logic [1:0] sync;
  logic [3:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      hist  <= 4'b1111;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      hist <= {sync[1], hist[3:1]};
      // level only moves once the whole history agrees
      if (hist == 4'b1111)
        level <= 1'b1;
      else if (hist == 4'b0000)
        level <= 1'b0;
    end
  end

  assign fall = (hist == 4'b0001);
  assign rise = (hist == 4'b1110);
endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter; PS2_HOST_TX_RETRY_EN enables up to two retries
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ         = 48000000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_US = 15000,
  parameter int FRAME_TIMEOUT_US = 2000
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         ps2_kbd_clk,
  input  logic         ps2_kbd_data,
  output logic         ps2_clk_drv,
  output logic         ps2_data_drv,
  ps2_host_tx_if.slave tx
);
  localparam int INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_FREQ);
  localparam int START_CYC   = us_to_cycles(START_TIMEOUT_US, CLK_FREQ);
  localparam int FRAME_CYC   = us_to_cycles(FRAME_TIMEOUT_US, CLK_FREQ);
  localparam int MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int MAX_CYC     = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
  localparam int TW          = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] INHIBIT_END = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] START_END   = TW'(START_CYC - 1);
  localparam logic [TW-1:0] FRAME_END   = TW'(FRAME_CYC - 1);

  ps2_tx_state_t state;
  logic [TW-1:0] timer;
  logic [9:0]    shift;
  logic [3:0]    bit_cnt;
  logic          ready_q, busy_q, done_q, err_q, nack_q;
  logic          clk_level, clk_fall, clk_rise;
  logic          data_level, data_fall, data_rise;
  logic          accept, in_frame, timeout, nack_fail, fail, last_try;
  logic          unused_edges;

  ps2_line_filter u_clk_filter (
    .clk(clk_sys), .rst_n(reset_n), .pin(ps2_kbd_clk),
    .level(clk_level), .fall(clk_fall), .rise(clk_rise)
  );

  ps2_line_filter u_data_filter (
    .clk(clk_sys), .rst_n(reset_n), .pin(ps2_kbd_data),
    .level(data_level), .fall(data_fall), .rise(data_rise)
  );

  assign unused_edges = &{1'b0, clk_rise, data_fall, data_rise};

`ifdef PS2_HOST_TX_RETRY_EN
  logic [9:0] frame_q;
  logic [1:0] retry_q;
  assign last_try = (retry_q == 2'(PS2_RETRIES));
`else
  assign last_try = 1'b1;
`endif

  assign accept    = tx.tx_valid & ready_q;
  assign in_frame  = (state == DATA) || (state == ACK) || (state == WAIT_IDLE);
  // a device edge on the very last start-timer cycle still counts
  assign timeout   = ((state == RTS) && (timer == START_END) && !clk_fall) ||
                     (in_frame && (timer == FRAME_END));
  assign nack_fail = (state == ACK) && clk_fall && data_level;
  assign fail      = timeout | nack_fail;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= '0;
      shift        <= '0;
      bit_cnt      <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      nack_q       <= 1'b0;
      ps2_clk_drv  <= 1'b0;
      ps2_data_drv <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      frame_q      <= '0;
      retry_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      nack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift       <= {1'b1, ~^tx.tx_data, tx.tx_data};
            bit_cnt     <= '0;
            timer       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            ps2_clk_drv <= 1'b1;
            state       <= INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
            frame_q     <= {1'b1, ~^tx.tx_data, tx.tx_data};
            retry_q     <= '0;
`endif
          end
        end
        INHIBIT: begin
          if (timer == INHIBIT_END) begin
            ps2_clk_drv  <= 1'b0;
            ps2_data_drv <= 1'b1;
            timer        <= '0;
            state        <= RTS;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RTS, DATA: begin
          timer <= timer + TW'(1);
          // the first device edge already carries bit 0; edge 10 puts the stop bit
          if (clk_fall) begin
            ps2_data_drv <= ~shift[0];
            shift        <= {1'b0, shift[9:1]};
            bit_cnt      <= bit_cnt + 4'd1;
            if (state == RTS) begin
              timer <= '0;
              state <= DATA;
            end else if (bit_cnt == 4'd9) begin
              state <= ACK;
            end
          end
        end
        ACK: begin
          timer        <= timer + TW'(1);
          ps2_data_drv <= 1'b0;
          if (clk_fall && !data_level)
            state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          timer <= timer + TW'(1);
          if (clk_level && data_level) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        ERR: begin
`ifdef PS2_HOST_TX_RETRY_EN
          if (!last_try) begin
            retry_q     <= retry_q + 2'd1;
            shift       <= frame_q;
            bit_cnt     <= '0;
            timer       <= '0;
            ps2_clk_drv <= 1'b1;
            state       <= INHIBIT;
          end else
`endif
          begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // failure overrides whatever the state branch decided this cycle
      if (fail) begin
        state        <= ERR;
        ps2_clk_drv  <= 1'b0;
        ps2_data_drv <= 1'b0;
        done_q       <= 1'b0;
        err_q        <= last_try;
        nack_q       <= last_try & nack_fail;
      end
    end
  end

  assign tx.tx_ready = ready_q;
  assign tx.busy     = busy_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_err   = err_q;
  assign tx.tx_nack  = nack_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;
  localparam int INH_CYC   = 100;   // 100 us at 1 MHz
  localparam int START_CYC = 5000;  // 5000 us at 1 MHz
  localparam int HALF      = 40;    // 12.5 kHz device clock at 1 MHz
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk_sys  = 1'b0;
  logic reset_n  = 1'b0;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_drv, ps2_data_drv;
  wire  pin_clk  = dev_clk & ~ps2_clk_drv;
  wire  pin_data = dev_data & ~ps2_data_drv;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .CLK_FREQ(1000000), .INHIBIT_US(100), .START_TIMEOUT_US(5000), .FRAME_TIMEOUT_US(2000)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ps2_kbd_clk(pin_clk), .ps2_kbd_data(pin_data),
    .ps2_clk_drv(ps2_clk_drv), .ps2_data_drv(ps2_data_drv),
    .tx(bus)
  );

  always #5 clk_sys = ~clk_sys;

  int   checks = 0, errors = 0;
  int   done_cnt = 0, err_cnt = 0, inh_cnt = 0;
  logic last_nack = 1'b0, prev_cdrv = 1'b0;

  always @(negedge clk_sys) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_err) begin
      err_cnt++;
      last_nack = bus.tx_nack;
    end
    if (ps2_clk_drv && !prev_cdrv) inh_cnt++;
    prev_cdrv = ps2_clk_drv;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_sys);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk_sys);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_rts(output bit ok);
    int n = 0;
    while (!(ps2_data_drv && !ps2_clk_drv) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    ok = (n < 2000);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rts_wait: got no request-to-send, expected one within 2000 cycles");
    end
  endtask

  task automatic dev_frame(input bit ack, input bit glitch, output logic [9:0] bits);
    bit ok;
    bits = '0;
    wait_rts(ok);
    if (ok) begin
      repeat (20) @(negedge clk_sys);
      for (int i = 0; i < 10; i++) begin
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        dev_clk = 1'b1;
        bits[i] = pin_data;
        if (glitch && i < 9) begin
          repeat (15) @(negedge clk_sys);
          dev_clk = 1'b0;
          repeat (2) @(negedge clk_sys);
          dev_clk = 1'b1;
          repeat (HALF - 17) @(negedge clk_sys);
        end else begin
          repeat (HALF) @(negedge clk_sys);
        end
      end
      if (ack) dev_data = 1'b0;
      repeat (10) @(negedge clk_sys);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      dev_clk = 1'b1;
      repeat (10) @(negedge clk_sys);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.tx_ready && n < 20000) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 20000) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: tx_ready still 0, expected 1 within 20000 cycles", tag);
    end
  endtask

  task automatic test_reset();
    logic [6:0] st;
    repeat (3) @(negedge clk_sys);
    st = {ps2_clk_drv, ps2_data_drv, bus.tx_ready, bus.busy, bus.tx_done, bus.tx_err, bus.tx_nack};
    checks++;
    if (st !== 7'b0010000) begin
      errors++; $display("FAIL reset_state: got %b expected %b", st, 7'b0010000);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    st = {ps2_clk_drv, ps2_data_drv, bus.tx_ready, bus.busy, bus.tx_done, bus.tx_err, bus.tx_nack};
    checks++;
    if (st !== 7'b0010000) begin
      errors++; $display("FAIL post_reset_idle: got %b expected %b", st, 7'b0010000);
    end
  endtask

  task automatic test_send_ed();
    logic [9:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(8'hED);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL ed_busy: got %b expected 1", bus.busy);
    end
    dev_frame(1'b1, 1'b0, bits);
    wait_ready("ed");
    checks++;
    if (bits !== 10'b11_1110_1101) begin
      errors++; $display("FAIL ed_bits: got %b expected %b", bits, 10'b11_1110_1101);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL ed_done_pulses: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++; $display("FAIL ed_err_pulses: got %0d expected 0", err_cnt - e0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL ed_busy_drop: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_parity_inhibit();
    logic [9:0] bits;
    int n = 0;
    int d0 = done_cnt;
    @(negedge clk_sys);
    bus.tx_data  = 8'h02;
    bus.tx_valid = 1'b1;
    @(negedge clk_sys);
    bus.tx_valid = 1'b0;
    while (ps2_clk_drv && !ps2_data_drv && n < 1000) begin
      n++;
      @(negedge clk_sys);
    end
    checks++;
    if (n !== INH_CYC) begin
      errors++; $display("FAIL inhibit_len: got %0d expected %0d", n, INH_CYC);
    end
    checks++;
    if ({ps2_clk_drv, ps2_data_drv} !== 2'b01) begin
      errors++; $display("FAIL rts_drive: got %b expected 01", {ps2_clk_drv, ps2_data_drv});
    end
    dev_frame(1'b1, 1'b0, bits);
    wait_ready("p02");
    checks++;
    if (bits !== 10'b10_0000_0010) begin
      errors++; $display("FAIL p02_bits: got %b expected %b", bits, 10'b10_0000_0010);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL p02_done_pulses: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_start_timeout();
    int e0 = err_cnt, i0 = inh_cnt, d0 = done_cnt;
    send_byte(8'h55);
`ifndef PS2_HOST_TX_RETRY_EN
    begin
      bit ok;
      int n = 0;
      wait_rts(ok);
      while (!bus.tx_err && n < 10000) begin
        @(negedge clk_sys);
        n++;
      end
      checks++;
      if (n !== START_CYC) begin
        errors++; $display("FAIL start_timeout_len: got %0d expected %0d", n, START_CYC);
      end
      checks++;
      if ({ps2_clk_drv, ps2_data_drv} !== 2'b00) begin
        errors++; $display("FAIL timeout_release: got %b expected 00", {ps2_clk_drv, ps2_data_drv});
      end
    end
`endif
    wait_ready("tmo");
    checks++;
    if (err_cnt - e0 !== 1 || last_nack !== 1'b0) begin
      errors++; $display("FAIL tmo_err: got %0d pulses nack %b expected 1 pulse nack 0", err_cnt - e0, last_nack);
    end
    checks++;
    if (inh_cnt - i0 !== ATTEMPTS) begin
      errors++; $display("FAIL tmo_attempts: got %0d expected %0d", inh_cnt - i0, ATTEMPTS);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++; $display("FAIL tmo_done: got %0d expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_nack();
    logic [9:0] bits;
    int e0 = err_cnt, i0 = inh_cnt, d0 = done_cnt;
    send_byte(8'hF3);
    for (int a = 0; a < ATTEMPTS; a++) dev_frame(1'b0, 1'b0, bits);
    wait_ready("nack");
    checks++;
    if (err_cnt - e0 !== 1 || last_nack !== 1'b1) begin
      errors++; $display("FAIL nack_err: got %0d pulses nack %b expected 1 pulse nack 1", err_cnt - e0, last_nack);
    end
    checks++;
    if (inh_cnt - i0 !== ATTEMPTS) begin
      errors++; $display("FAIL nack_attempts: got %0d expected %0d", inh_cnt - i0, ATTEMPTS);
    end
    checks++;
    if (done_cnt - d0 !== 0 || ps2_data_drv !== 1'b0) begin
      errors++; $display("FAIL nack_done: got %0d done data_drv %b expected 0 done data_drv 0", done_cnt - d0, ps2_data_drv);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    logic [3:0] st;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(8'h00);
    wait_rts(ok);
    repeat (20) @(negedge clk_sys);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk_sys);
    end
    dev_clk = 1'b0;
    repeat (HALF / 2) @(negedge clk_sys);
    checks++;
    if (ps2_data_drv !== 1'b1) begin
      errors++; $display("FAIL mid_bit4_drive: got %b expected 1", ps2_data_drv);
    end
    #2 reset_n = 1'b0;
    #1;
    st = {ps2_clk_drv, ps2_data_drv, bus.tx_ready, bus.busy};
    checks++;
    if (st !== 4'b0010) begin
      errors++; $display("FAIL mid_reset_async: got %b expected 0010", st);
    end
    dev_clk = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL mid_reset_pulses: got done %0d err %0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    send_byte(8'hFF);
    dev_frame(1'b1, 1'b0, bits);
    wait_ready("ff");
    checks++;
    if (bits !== 10'b11_1111_1111 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL ff_after_reset: got bits %b done %0d expected %b done 1", bits, done_cnt - d0, 10'b11_1111_1111);
    end
  endtask

  task automatic test_glitch();
    logic [9:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(8'hA5);
    dev_frame(1'b1, 1'b1, bits);
    wait_ready("glitch");
    checks++;
    if (bits !== 10'b11_1010_0101) begin
      errors++; $display("FAIL glitch_bits: got %b expected %b", bits, 10'b11_1010_0101);
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL glitch_result: got done %0d err %0d expected 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_idle_clocking();
    int bad = 0;
    int d0 = done_cnt, e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      dev_clk = ~dev_clk;
      repeat (20) begin
        @(negedge clk_sys);
        if (ps2_clk_drv || ps2_data_drv || bus.busy) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL idle_drive: got %0d driven cycles expected 0", bad);
    end
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || bus.tx_ready !== 1'b1) begin
      errors++; $display("FAIL idle_pulses: got done %0d err %0d ready %b expected 0 0 1", done_cnt - d0, err_cnt - e0, bus.tx_ready);
    end
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset();
    test_send_ed();
    test_parity_inhibit();
    test_start_timeout();
    test_nack();
    test_reset_mid();
    test_glitch();
    test_idle_clocking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
